// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix lines plus the downstream key valid/ready handshake.
interface keypad_scanner_if;
  logic [3:0] keyboard;
  logic [3:0] col_n;
  logic [1:0] counter;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_down;
  logic       overrun;
  modport master (
    input  keyboard, key_ready,
    output col_n, counter, key_code, key_valid, key_down, overrun
  );
  modport slave (
    output keyboard, key_ready,
    input  col_n, counter, key_code, key_valid, key_down, overrun
  );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad column scanner, sweep-level debounce, one code per press via valid/ready.
module keypad_scanner #(
  parameter int SETTLE_CYCLES   = 8,
  parameter int DEBOUNCE_SWEEPS = 4
) (
  input logic              clock_i,
  input logic              reset_n_i,
  keypad_scanner_if.master kp_if
);
  localparam int DW = $clog2(SETTLE_CYCLES);
  localparam int CW = $clog2(DEBOUNCE_SWEEPS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE_SWEEPS);
  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_e;
  state_e        state_q, state_d;
  logic [3:0]    sync1_q, sync2_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    acc_q, acc_d;
  logic [3:0]    acc_code_q, acc_code_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d, overrun_q, overrun_d;
  logic [2:0]    zeros, acc_sum;
  logic [1:0]    row, samp_kind, sweep_n;
  logic [3:0]    samp_code;
  logic          sample, eval, none, single, emit, accept_ok;
  always_comb begin
    zeros = '0;
    row   = '0;
    for (int i = 0; i < 4; i++) begin
      zeros = zeros + {2'b00, ~sync2_q[i]};
      row   = sync2_q[i] ? row : 2'(i);
    end
  end
  assign sample     = dwell_q == DWELL_LAST;
  assign eval       = sample && col_q == 2'd3;
  assign dwell_d    = sample ? '0 : dwell_q + 1'b1;
  assign col_d      = col_q + {1'b0, sample};
  assign samp_kind  = zeros == 3'd0 ? 2'd0 : zeros == 3'd1 ? 2'd1 : 2'd2;
  assign samp_code  = {row, col_q} + 4'd1;
  // acc counts keys seen this sweep, saturating at 2 (= multi); column 0 starts a fresh sweep
  assign acc_sum    = (col_q == 2'd0 ? 3'd0 : {1'b0, acc_q}) + {1'b0, samp_kind};
  assign sweep_n    = acc_sum > 3'd2 ? 2'd2 : acc_sum[1:0];
  assign acc_d      = sample ? sweep_n : acc_q;
  assign acc_code_d = sample && samp_kind == 2'd1 ? samp_code : acc_code_q;
  assign none       = sweep_n == 2'd0;
  assign single     = sweep_n == 2'd1;
  assign cnt_inc    = cnt_q + 1'b1;
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    emit    = 1'b0;
    if (eval) begin
      case (state_q)
        IDLE, DEBOUNCE: begin
          if (single) begin
            cand_d  = acc_code_d;
            cnt_d   = state_q == DEBOUNCE && acc_code_d == cand_q ? cnt_inc : CNT_ONE;
            emit    = cnt_d == CNT_DONE;
            state_d = emit ? PRESSED : DEBOUNCE;
          end else begin
            state_d = IDLE;
          end
        end
        PRESSED: begin
          if (none || (single && acc_code_d != cand_q)) begin
            cnt_d   = CNT_ONE;
            state_d = CNT_ONE == CNT_DONE ? IDLE : RELEASE;
          end
        end
        default: begin
          cnt_d   = cnt_inc;
          state_d = !none ? PRESSED : cnt_inc == CNT_DONE ? IDLE : RELEASE;
        end
      endcase
    end
  end
  // a pending code is only replaced when the consumer takes it on the same clock
  assign accept_ok = !valid_q || kp_if.key_ready;
  assign code_d    = emit && accept_ok ? cand_d : code_q;
  assign valid_d   = (emit && accept_ok) || (valid_q && !kp_if.key_ready);
  assign overrun_d = emit && !accept_ok;
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      sync1_q    <= 4'hF;
      sync2_q    <= 4'hF;
      dwell_q    <= '0;
      col_q      <= '0;
      acc_q      <= '0;
      acc_code_q <= '0;
      state_q    <= IDLE;
      cand_q     <= '0;
      cnt_q      <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync1_q    <= kp_if.keyboard;
      sync2_q    <= sync1_q;
      dwell_q    <= dwell_d;
      col_q      <= col_d;
      acc_q      <= acc_d;
      acc_code_q <= acc_code_d;
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end
  assign kp_if.col_n     = ~(4'b0001 << col_q);
  assign kp_if.counter   = col_q;
  assign kp_if.key_code  = code_q;
  assign kp_if.key_valid = valid_q;
  assign kp_if.key_down  = state_q == PRESSED || state_q == RELEASE;
  assign kp_if.overrun   = overrun_q;
endmodule
